// File: rtl/bshift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bshift_pkg
// Description : Shared widths, shift op codes and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package bshift_pkg;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : bshift_pkg
`default_nettype wire

// File: rtl/barrel_shift4.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift4
// Description : Combinational 4-bit shifter: SLL, SRL, SRA, ROL by 0-3.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift4
  import bshift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] w_rot;

  // Rotate = upper half of the doubled operand after a left shift.
  assign w_rot = {data, data} << amt;

  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = data << amt;
      OP_SRL:  result = data >> amt;
      OP_SRA:  result = $signed(data) >>> amt;
      OP_ROL:  result = w_rot[2*DATA_W-1:DATA_W];
      default: result = data;
    endcase
  end

endmodule : barrel_shift4
`default_nettype wire

// File: rtl/bshift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bshift_arbiter
// Description : Two-requester arbiter feeding one shared shifter and a
//               single-entry result register with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bshift_arbiter
  import bshift_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [AMT_W-1:0]  a_amt,
  input  logic [1:0]        a_op,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [AMT_W-1:0]  b_amt,
  input  logic [1:0]        b_op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_src
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_b;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_src;

  logic              w_slot_free;
  logic              w_tie_a;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;
  logic [AMT_W-1:0]  w_sel_amt;
  logic [1:0]        w_sel_op;
  logic [DATA_W-1:0] w_shift_res;

  // Who wins when both requesters are valid.
  if (RR_EN != 0) begin : g_rr
    assign w_tie_a = r_last_b;
  end else begin : g_fixed
    assign w_tie_a = 1'b1;
  end

  always_comb begin
    w_slot_free = (r_state == ST_IDLE) || res_ready;
    w_grant_a   = a_valid && (!b_valid || w_tie_a);
    w_grant_b   = b_valid && !w_grant_a;
    a_ready     = !rst && w_slot_free && w_grant_a;
    b_ready     = !rst && w_slot_free && w_grant_b;
    w_accept    = a_ready || b_ready;
    w_sel_data  = w_grant_b ? b_data : a_data;
    w_sel_amt   = w_grant_b ? b_amt  : a_amt;
    w_sel_op    = w_grant_b ? b_op   : a_op;
  end

  barrel_shift4 u_shift (
    .data   (w_sel_data),
    .amt    (w_sel_amt),
    .op     (w_sel_op),
    .result (w_shift_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_accept)       w_state_nxt = ST_HOLD;
        else if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pointer resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_data <= '0;
      r_res_src  <= 1'b0;
      r_last_b   <= 1'b1;
    end else if (w_accept) begin
      r_res_data <= w_shift_res;
      r_res_src  <= w_grant_b;
      r_last_b   <= w_grant_b;
    end
  end

  // Outputs read as empty for the whole reset cycle.
  assign res_valid = !rst && (r_state == ST_HOLD);
  assign res_data  = rst ? '0 : r_res_data;
  assign res_src   = !rst && r_res_src;

endmodule : bshift_arbiter
`default_nettype wire

// File: tb/tb_bshift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bshift_arbiter
// Description : Directed plus random bench for round-robin and fixed-priority
//               instances against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bshift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, res_ready;
  logic [3:0] a_data, b_data;
  logic [1:0] a_amt, b_amt, a_op, b_op;
  logic [1:0] a_ready, b_ready, res_valid, res_src;
  logic [3:0] res_data [2];

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus values applied on the next step.
  logic       t_rst, t_av, t_bv, t_rr;
  logic [3:0] t_ad, t_bd;
  logic [1:0] t_aa, t_ba, t_ao, t_bo;

  // Reference model state, index 0 = round robin, 1 = fixed priority.
  bit       m_hold  [2];
  int       m_data  [2];
  bit       m_src   [2];
  bit       m_lastb [2];

  always #5 clk = ~clk;

  bshift_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[0]), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready[0]), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_data(res_data[0]), .res_src(res_src[0])
  );

  bshift_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready[1]), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready[1]), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_data(res_data[1]), .res_src(res_src[1])
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Shift semantics from plain integer arithmetic.
  function automatic int ref_shift(int d, int amt, int op);
    int p;
    int sv;
    p = 1 << amt;
    case (op)
      0: return (d * p) % 16;
      1: return d / p;
      2: begin
        sv = (d >= 8) ? d - 16 : d;
        sv = (sv < 0) ? -((-sv + p - 1) / p) : sv / p;
        return sv & 15;
      end
      default: return ((d * p) + d / (16 / p)) % 16;
    endcase
  endfunction

  task automatic step();
    bit ga, gb, slot, ra, rb;
    @(negedge clk);
    rst = t_rst; a_valid = t_av; b_valid = t_bv; res_ready = t_rr;
    a_data = t_ad; a_amt = t_aa; a_op = t_ao;
    b_data = t_bd; b_amt = t_ba; b_op = t_bo;
    #1;
    for (int k = 0; k < 2; k++) begin
      slot = !m_hold[k] || t_rr;
      ga   = t_av && (!t_bv || k == 1 || m_lastb[k]);
      gb   = t_bv && !ga;
      ra   = !t_rst && slot && ga;
      rb   = !t_rst && slot && gb;
      chk($sformatf("a_ready[%0d]", k), int'(a_ready[k]), int'(ra));
      chk($sformatf("b_ready[%0d]", k), int'(b_ready[k]), int'(rb));
      chk($sformatf("res_valid[%0d]", k), int'(res_valid[k]), int'(!t_rst && m_hold[k]));
      if (t_rst) begin
        chk($sformatf("rst_data[%0d]", k), int'(res_data[k]), 0);
        chk($sformatf("rst_src[%0d]", k), int'(res_src[k]), 0);
      end else if (m_hold[k]) begin
        chk($sformatf("res_data[%0d]", k), int'(res_data[k]), m_data[k]);
        chk($sformatf("res_src[%0d]", k), int'(res_src[k]), int'(m_src[k]));
      end
      if (t_rst) begin
        m_hold[k] = 0; m_data[k] = 0; m_src[k] = 0; m_lastb[k] = 1;
      end else if (ra || rb) begin
        m_hold[k]  = 1;
        m_data[k]  = rb ? ref_shift(t_bd, t_ba, t_bo) : ref_shift(t_ad, t_aa, t_ao);
        m_src[k]   = rb;
        m_lastb[k] = rb;
      end else if (t_rr) begin
        m_hold[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    t_rst = 0; t_av = 0; t_bv = 0; t_rr = 1;
    t_ad = 4'h0; t_aa = 2'd0; t_ao = 2'd0;
    t_bd = 4'h0; t_ba = 2'd0; t_bo = 2'd0;
  endtask

  task automatic do_reset();
    set_idle(); t_rst = 1;
    step(); step();
    t_rst = 0;
  endtask

  logic [3:0] op_d   [5] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1001};
  logic [1:0] op_a   [5] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd3};
  logic [1:0] op_o   [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [3:0] op_exp [5] = '{4'b0110, 4'b0010, 4'b1110, 4'b0111, 4'b1100};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_data[k] = 0; m_src[k] = 0; m_lastb[k] = 1;
    end
    do_reset();

    // Op checks, A only
    for (int i = 0; i < 5; i++) begin
      set_idle(); t_av = 1; t_ad = op_d[i]; t_aa = op_a[i]; t_ao = op_o[i];
      step();
      chk($sformatf("op%0d_data", i), int'(res_data[0]), int'(op_exp[i]));
      chk($sformatf("op%0d_src", i), int'(res_src[0]), 0);
    end
    // amt = 0 leaves the operand unchanged
    for (int i = 0; i < 4; i++) begin
      set_idle(); t_av = 1; t_ad = 4'b0110; t_ao = 2'(i);
      step();
      chk($sformatf("amt0_op%0d", i), int'(res_data[0]), 6);
    end

    // Alternation from reset: A,B,A,B for RR, always A for fixed
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle(); t_av = 1; t_bv = 1; t_ad = 4'(i); t_bd = 4'(i + 8);
      step();
      chk($sformatf("rr_src%0d", i), int'(res_src[0]), i % 2);
      chk($sformatf("fp_src%0d", i), int'(res_src[1]), 0);
    end

    // Backpressure then pending B accepted as soon as the slot frees
    set_idle(); t_av = 1; t_ad = 4'b0011; t_aa = 2'd1;
    step();
    for (int i = 0; i < 4; i++) begin
      set_idle(); t_rr = 0; t_bv = 1; t_bd = 4'b1000; t_ba = 2'd1; t_bo = 2'b10;
      step();
      chk($sformatf("bp_hold%0d", i), int'(res_data[0]), 6);
    end
    t_rr = 1;
    step();
    chk("bp_b_data", int'(res_data[0]), 4'b1100);
    chk("bp_b_src", int'(res_src[0]), 1);

    // Reset while holding a result, then a tie goes to A
    set_idle(); t_rr = 0; t_rst = 1;
    step();
    set_idle(); t_av = 1; t_bv = 1; t_ad = 4'h5; t_bd = 4'hA;
    step();
    chk("rst_tie_src", int'(res_src[0]), 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      t_rst = ($urandom_range(0, 59) == 0);
      t_av  = $urandom_range(0, 1);
      t_bv  = $urandom_range(0, 1);
      t_rr  = ($urandom_range(0, 9) < 7);
      t_ad  = 4'($urandom); t_aa = 2'($urandom); t_ao = 2'($urandom);
      t_bd  = 4'($urandom); t_ba = 2'($urandom); t_bo = 2'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bshift_arbiter
`default_nettype wire

// File: doc/bshift_arbiter.md
BSHIFT_ARBITER -- requirements
Module: bshift_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin between requesters, 0 = fixed priority with A highest.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a_valid  input  1  requester A has a shift request.
REQ-006 a_ready  output  1  block accepts A's request this cycle.
REQ-007 a_data  input  4  A operand.
REQ-008 a_amt  input  2  A shift amount, 0-3.
REQ-009 a_op  input  2  A operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 b_valid, b_ready, b_data, b_amt, b_op SHALL have the same directions, widths and meanings as the A ports, for requester B.
REQ-011 res_valid  output  1  result register holds an undelivered result.
REQ-012 res_ready  input  1  consumer takes the result this cycle.
REQ-013 res_data  output  4  shifted result.
REQ-014 res_src  output  1  requester that owns the result: 0 = A, 1 = B.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE (result register empty) and HOLD (res_valid=1).
REQ-016 Slot free: slot_free = (state==IDLE) or (res_ready==1).
REQ-017 Grant: when slot_free, the block SHALL grant exactly one valid requester; x_ready=1 only for the granted requester; no grant when neither is valid.
REQ-018 Tie, RR_EN=1: when both requesters are valid, the block SHALL grant the requester not granted most recently.
REQ-019 Tie, RR_EN=0: when both requesters are valid, the block SHALL always grant A.
REQ-020 The last-grant pointer SHALL update only on an accepted transfer (valid and ready both high).
REQ-021 On an accept, the block SHALL register the result and requester ID; res_valid=1 on the next cycle (latency 1); state becomes HOLD.
REQ-022 In HOLD with res_ready=0, res_data and res_src SHALL remain stable and both x_ready SHALL be 0.
REQ-023 In HOLD with res_ready=1 and a new accept, the block SHALL load the new result with no bubble (one result per cycle).
REQ-024 In HOLD with res_ready=1 and no accept, the block SHALL move to IDLE with res_valid=0.
REQ-025 SLL SHALL shift left and zero-fill the vacated bits.
REQ-026 SRL SHALL shift right and zero-fill the vacated bits.
REQ-027 SRA SHALL shift right and fill with data[3].
REQ-028 ROL SHALL rotate left by amt modulo 4.
REQ-029 For every op, amt=0 SHALL return the operand unchanged.
REQ-030 Only 4 result bits SHALL be kept; bits shifted out are discarded.
REQ-031 A requester that drops valid before it is granted SHALL lose nothing; the block SHALL keep no request state.

Reset
REQ-032 While rst=1, the block SHALL hold: state IDLE, res_valid 0, res_data 0000, res_src 0, a_ready 0, b_ready 0.
REQ-033 The last-grant pointer SHALL reset to B, so A wins the first tie.
REQ-034 A reset during HOLD SHALL discard the pending result; res_valid SHALL be 0 in the cycle after the reset edge.
REQ-035 A request presented in the reset cycle SHALL NOT be accepted.

Structure
REQ-036 Shared package bshift_pkg SHALL hold the op codes (OP_SLL, OP_SRL, OP_SRA, OP_ROL), the FSM state typedef, and the constants DATA_W=4 and AMT_W=2.
REQ-037 Sub-module barrel_shift4 (combinational; inputs data, amt, op; output result) SHALL be instantiated once and shared through the grant mux.
REQ-038 The arbitration, FSM and result register SHALL live in bshift_arbiter.

Verification
REQ-039 Op checks, A only, res_ready=1: SLL 1011 amt1 -> 0110; SRL 1011 amt2 -> 0010; SRA 1011 amt2 -> 1110; ROL 1011 amt1 -> 0111; ROL 1001 amt3 -> 1100. Each result SHALL appear one cycle after accept with res_src=0.
REQ-040 Round robin, RR_EN=1, both valid every cycle, res_ready=1: grants SHALL be A,B,A,B; res_src SHALL follow 0,1,0,1 with one result per cycle.
REQ-041 Fixed priority, RR_EN=0, both valid for 3 cycles: A SHALL be granted all 3 cycles; b_ready SHALL stay 0.
REQ-042 Backpressure: res_ready=0 for 4 cycles after an accept -> res_valid=1, res_data stable, both ready=0; res_ready=1 -> pending B request accepted that same cycle.
REQ-043 Reset in HOLD: assert rst for 1 cycle -> res_valid=0 next cycle; next tie grants A.
REQ-044 amt=0 for all 4 ops on operand 0110 -> result 0110 each time.
